punc_dmem_responder: RTL and testbench

- Responder side of the PUnC data-memory interface. It serves the single-outstanding read and write requests issued by the processor control and datapath.
- Backs a word-addressed RAM with a configurable number of wait states.
- Decodes two memory-mapped display registers (DSR/DDR) and drives an output handshake toward a console or testbench sink.

---
 rtl/punc_mem_pkg.sv | 21 ++
 rtl/punc_dmem_array.sv | 31 +++
 rtl/punc_dmem_responder.sv | 159 +++++++++++++++
 tb/tb_punc_dmem_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/punc_mem_pkg.sv
// Shared definitions for the PUnC data-memory responder.
//   DSR_ADDR / DDR_ADDR : memory-mapped display status / data registers
//   rsp_state_e         : responder FSM state encoding
//   is_ddr_write()      : true when a request is a write to the display data register
package punc_mem_pkg;

  localparam logic [15:0] DSR_ADDR = 16'hFE04;
  localparam logic [15:0] DDR_ADDR = 16'hFE06;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DOUT = 2'd2,
    ST_RESP = 2'd3
  } rsp_state_e;

  function automatic logic is_ddr_write(input logic we, input logic [15:0] addr);
    return we && (addr == DDR_ADDR);
  endfunction

endpackage

// File: rtl/punc_dmem_array.sv
// Word-addressed data RAM: 2^ADDR_W x 16, synchronous write, combinational read, no reset.
// Ports:
//   clk   in   clock
//   we    in   write enable (commits at the rising edge)
//   addr  in   word address
//   wdata in   write data
//   rdata out  read data for addr (combinational)
module punc_dmem_array #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [15:0] mem [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/punc_dmem_responder.sv
// Responder side of the PUnC data-memory interface. Serves one outstanding
// read/write at a time against a RAM with LATENCY wait states, decodes the
// DSR/DDR display registers and hands DDR writes to a console sink.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_we, req_addr, req_wdata    request payload (word address)
//   rsp_valid, rsp_data            one-cycle response strobe and read data
//   dout_valid, dout_data          display character toward the sink
//   dout_ready                     sink accepts the character
//   err                            sticky out-of-range access flag
module punc_dmem_responder
  import punc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        dout_valid,
  output logic [15:0] dout_data,
  input  logic        dout_ready,
  output logic        err
);

  localparam int unsigned CNT_W    = 4;
  localparam logic        ZERO_LAT = (LATENCY == 0);

  rsp_state_e        state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              we_q;
  logic [15:0]       addr_q;
  logic [15:0]       wdata_q;

  logic              accept;
  logic              cur_we;
  logic [15:0]       cur_addr;
  logic              cur_ram;
  logic              cur_ok;
  logic              err_set;
  logic              ram_we;
  logic [15:0]       ram_rdata;

  // In IDLE decode the incoming request, otherwise the latched one
  always_comb begin
    cur_we   = we_q;
    cur_addr = addr_q;
    if (state_q == ST_IDLE) begin
      cur_we   = req_we;
      cur_addr = req_addr;
    end
  end

  assign cur_ram = ((cur_addr >> ADDR_W) == 16'd0);
  assign cur_ok  = cur_ram || (cur_addr == DSR_ADDR) || (cur_addr == DDR_ADDR);

  // Next-state, wait counter and request acceptance
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          cnt_n  = CNT_W'(LATENCY);
          if (ZERO_LAT) begin
            state_n = is_ddr_write(cur_we, cur_addr) ? ST_DOUT : ST_RESP;
          end else begin
            state_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_n = is_ddr_write(cur_we, cur_addr) ? ST_DOUT : ST_RESP;
        end
      end
      ST_DOUT: begin
        if (dout_ready) begin
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // err is raised as a bad access enters RESP so it is visible with rsp_valid
  assign err_set = ((state_q == ST_IDLE) || (state_q == ST_WAIT)) &&
                   (state_n == ST_RESP) && !cur_ok;

  // State, request latch and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      req_ready  <= (state_n == ST_IDLE);
      rsp_valid  <= (state_n == ST_RESP);
      dout_valid <= (state_n == ST_DOUT);
      err        <= err | err_set;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // RAM write commits on the edge that leaves RESP; abandoned by reset otherwise
  assign ram_we = (state_q == ST_RESP) && we_q && cur_ram;

  punc_dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_q[ADDR_W-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Read data is sampled in RESP; DSR reflects the live sink readiness
  always_comb begin
    rsp_data = 16'd0;
    if ((state_q == ST_RESP) && !we_q) begin
      if (cur_ram) begin
        rsp_data = ram_rdata;
      end else if (addr_q == DSR_ADDR) begin
        rsp_data = {dout_ready, 15'd0};
      end
    end
  end

  assign dout_data = (state_q == ST_DOUT) ? wdata_q : 16'd0;

endmodule

// File: tb/tb_punc_dmem_responder.sv
// Directed bench for punc_dmem_responder: one instance at LATENCY=2 for the
// main vector table and multi-cycle sequences, one at LATENCY=0 for the
// back-to-back throughput case.
module tb_punc_dmem_responder;

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        dout_valid;
  logic [15:0] dout_data;
  logic        dout_ready;
  logic        err;

  logic        req_valid0, req_ready0, req_we0;
  logic [15:0] req_addr0, req_wdata0;
  logic        rsp_valid0;
  logic [15:0] rsp_data0;
  logic        dout_valid0;
  logic [15:0] dout_data0;
  logic        dout_ready0;
  logic        err0;

  int n_vec;
  int n_bad;

  punc_dmem_responder #(.ADDR_W(12), .LATENCY(2)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .dout_valid (dout_valid),
    .dout_data  (dout_data),
    .dout_ready (dout_ready),
    .err        (err)
  );

  punc_dmem_responder #(.ADDR_W(12), .LATENCY(0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid0),
    .req_ready  (req_ready0),
    .req_we     (req_we0),
    .req_addr   (req_addr0),
    .req_wdata  (req_wdata0),
    .rsp_valid  (rsp_valid0),
    .rsp_data   (rsp_data0),
    .dout_valid (dout_valid0),
    .dout_data  (dout_data0),
    .dout_ready (dout_ready0),
    .err        (err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        dr;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on the LATENCY=2 instance; entered and left at a negedge with the DUT idle
  task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                     output logic [15:0] data, output logic e, output int lat);
    logic found;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    found = 1'b0;
    lat   = -1;
    data  = 16'hxxxx;
    e     = 1'bx;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1'b1;
        lat   = k;
        data  = rsp_data;
        e     = err;
      end
    end
    @(negedge clk);
    chk("rsp_one_shot", 16'(rsp_valid), 16'd0);
  endtask

  vec_t        tbl[12];
  logic [15:0] d;
  logic        e;
  int          lat;
  int          k;
  logic        seen;

  initial begin
    n_vec = 0;
    n_bad = 0;

    tbl[0]  = '{"wr_0010",     1'b1, 16'h0010, 16'h1234, 1'b1, 16'h0000, 1'b0};
    tbl[1]  = '{"rd_0010",     1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234, 1'b0};
    tbl[2]  = '{"wr_0000",     1'b1, 16'h0000, 16'hA5A5, 1'b1, 16'h0000, 1'b0};
    tbl[3]  = '{"wr_0fff",     1'b1, 16'h0FFF, 16'h7777, 1'b1, 16'h0000, 1'b0};
    tbl[4]  = '{"rd_0fff",     1'b0, 16'h0FFF, 16'h0000, 1'b1, 16'h7777, 1'b0};
    tbl[5]  = '{"wr_0020",     1'b1, 16'h0020, 16'h5555, 1'b1, 16'h0000, 1'b0};
    tbl[6]  = '{"rd_dsr_rdy",  1'b0, 16'hFE04, 16'h0000, 1'b1, 16'h8000, 1'b0};
    tbl[7]  = '{"rd_dsr_busy", 1'b0, 16'hFE04, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[8]  = '{"rd_ddr",      1'b0, 16'hFE06, 16'h0000, 1'b1, 16'h0000, 1'b0};
    tbl[9]  = '{"rd_oor_2000", 1'b0, 16'h2000, 16'h0000, 1'b1, 16'h0000, 1'b1};
    tbl[10] = '{"wr_oor_3000", 1'b1, 16'h3000, 16'hDEAD, 1'b1, 16'h0000, 1'b1};
    tbl[11] = '{"rd_0000",     1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, 1'b1};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    dout_ready = 1'b1;
    req_valid0 = 1'b0;
    req_we0    = 1'b0;
    req_addr0  = '0;
    req_wdata0 = '0;
    dout_ready0 = 1'b1;

    // Reset state
    #3;
    chk("rst_req_ready",  16'(req_ready),  16'd1);
    chk("rst_rsp_valid",  16'(rsp_valid),  16'd0);
    chk("rst_rsp_data",   rsp_data,        16'd0);
    chk("rst_dout_valid", 16'(dout_valid), 16'd0);
    chk("rst_dout_data",  dout_data,       16'd0);
    chk("rst_err",        16'(err),        16'd0);
    chk("rst_req_ready0", 16'(req_ready0), 16'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Vector table on the LATENCY=2 instance
    for (int i = 0; i < 12; i++) begin
      dout_ready = tbl[i].dr;
      txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, d, e, lat);
      chk({tbl[i].name, "_data"}, d, tbl[i].exp_data);
      chk({tbl[i].name, "_lat"},  16'(lat), 16'd3);
      chk({tbl[i].name, "_err"},  16'(e), 16'(tbl[i].exp_err));
    end
    chk("err_sticky", 16'(err), 16'd1);

    // DDR write stalled by the sink for 5 cycles
    dout_ready = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 16'hFE06;
    req_wdata  = 16'h0041;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (dout_valid) seen = 1'b1;
    end
    chk("ddr_dout_start", 16'(k), 16'd3);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("ddr_dout_valid", 16'(dout_valid), 16'd1);
      chk("ddr_dout_data",  dout_data,       16'h0041);
      chk("ddr_no_rsp",     16'(rsp_valid),  16'd0);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    chk("ddr_rsp_valid",  16'(rsp_valid),  16'd1);
    chk("ddr_rsp_data",   rsp_data,        16'd0);
    chk("ddr_dout_drop",  16'(dout_valid), 16'd0);
    @(negedge clk);
    chk("ddr_rsp_once",   16'(rsp_valid),  16'd0);

    // Back-to-back on LATENCY=0: write, then req_valid held for two reads
    req_valid0 = 1'b1;
    req_we0    = 1'b1;
    req_addr0  = 16'h0005;
    req_wdata0 = 16'h0BAD;
    @(posedge clk);
    #1 req_we0 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("b2b_rsp_valid", 16'(rsp_valid0), (c % 2 == 0) ? 16'd1 : 16'd0);
      chk("b2b_req_ready", 16'(req_ready0), (c % 2 == 0) ? 16'd0 : 16'd1);
      if (c == 2 || c == 4) chk("b2b_rsp_data", rsp_data0, 16'h0BAD);
      if (c == 5) req_valid0 = 1'b0;
    end
    @(negedge clk);
    chk("b2b_quiet", 16'(rsp_valid0), 16'd0);

    // Reset during WAIT abandons a pending write
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0020;
    req_wdata = 16'hBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rstw_req_ready", 16'(req_ready), 16'd1);
    chk("rstw_err",       16'(err),       16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("rstw_no_rsp", 16'(seen), 16'd0);
    txn(1'b0, 16'h0020, 16'h0000, d, e, lat);
    chk("rstw_rd_data", d, 16'h5555);
    chk("rstw_rd_err",  16'(e), 16'd0);
    chk("rstw_rd_lat",  16'(lat), 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
